// File: rtl/aes_arb_pkg.sv
// rtl/aes_arb_pkg.sv - shared types and constants for the AES engine arbiter
//
// Purpose : FSM state type, requester indices, bus widths and the default
//           WAIT timeout used by aes_arbiter, rr_arb2 and aes_arbiter_if.
// Ports   : none (package).
package aes_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int REQ_UART        = 0;
  localparam int REQ_CATCORE     = 1;
  localparam int N_REQ           = 2;
  localparam int BLK_W           = 128;
  localparam int TIMEOUT_DEFAULT = 63;

  // Requester index to its one-hot position on the 2-bit handshake vectors.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/aes_arbiter_if.sv
// rtl/aes_arbiter_if.sv - requester and engine bus bundle for aes_arbiter
//
// Purpose : groups the requester handshake/operand bus and the AES core
//           operand/strobe/result bus.
// Modports: slave  - the arbiter (accepts requests, drives the engine)
//           master - the requesters and cores around it
// Signals : req_valid/req_ready/req_dec [2], req_key/req_data [256],
//           rsp_valid [2], rsp_data [128], rsp_err,
//           eng_key/eng_data [128], eng_enc_start/eng_dec_start,
//           eng_enc_valid/eng_dec_valid, eng_enc_res/eng_dec_res [128].
interface aes_arbiter_if;
  import aes_arb_pkg::*;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       req_dec;
  logic [N_REQ*BLK_W-1:0] req_key;
  logic [N_REQ*BLK_W-1:0] req_data;

  logic [N_REQ-1:0]       rsp_valid;
  logic [BLK_W-1:0]       rsp_data;
  logic                   rsp_err;

  logic [BLK_W-1:0]       eng_key;
  logic [BLK_W-1:0]       eng_data;
  logic                   eng_enc_start;
  logic                   eng_dec_start;
  logic                   eng_enc_valid;
  logic                   eng_dec_valid;
  logic [BLK_W-1:0]       eng_enc_res;
  logic [BLK_W-1:0]       eng_dec_res;

  modport slave (
    input  req_valid, req_dec, req_key, req_data,
    input  eng_enc_valid, eng_dec_valid, eng_enc_res, eng_dec_res,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output eng_key, eng_data, eng_enc_start, eng_dec_start
  );

  modport master (
    output req_valid, req_dec, req_key, req_data,
    output eng_enc_valid, eng_dec_valid, eng_enc_res, eng_dec_res,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  eng_key, eng_data, eng_enc_start, eng_dec_start
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way round-robin arbiter with internal last-grant pointer
//
// Purpose : picks one of two requesters; on a tie the one that was not
//           granted last wins. The pointer only moves when the owner of
//           the grant is told to update it (end of an operation).
// Ports   : clk, nreset (sync active-low)
//           req[2]     - request vector
//           update     - load last_grant from upd_idx this cycle
//           upd_idx    - requester that just completed
//           gnt_valid  - any request present
//           gnt_idx    - index of the winning requester
module rr_arb2
  import aes_arb_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_idx,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // Starts at CatCore so that the UART path wins the first tie.
  logic last_grant;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      last_grant <= 1'(REQ_CATCORE);
    end else if (update) begin
      last_grant <= upd_idx;
    end
  end

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'(REQ_UART);
    case (req)
      2'b01:   gnt_idx = 1'(REQ_UART);
      2'b10:   gnt_idx = 1'(REQ_CATCORE);
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'(REQ_UART);
    endcase
  end

endmodule

// File: rtl/aes_arbiter.sv
// rtl/aes_arbiter.sv - shares one AES encrypt/decrypt core pair between two requesters
//
// Purpose : accepts one request at a time (UART command path = 0, CatCore
//           decrypt path = 1), issues it to the encrypt or decrypt core,
//           waits for the result with a timeout, and returns it to the
//           requester that owns the operation.
// Ports   : clk        - single clock, rising edge
//           nreset     - synchronous active-low reset
//           bus        - aes_arbiter_if.slave (requester + engine buses)
//           busy       - high whenever the FSM is not IDLE
//           eng_nreset - engine reset; pulses low for one cycle on timeout
module aes_arbiter
  import aes_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          nreset,
  aes_arbiter_if.slave  bus,
  output logic          busy,
  output logic          eng_nreset
);

  localparam int                TMR_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic [TMR_W-1:0]  timer_q;
  logic [BLK_W-1:0]  key_q, data_q, rsp_data_q;
  logic              dec_q, grant_q, rsp_err_q;

  logic              gnt_valid, gnt_idx;
  logic              accept, abort, resp_done;
  logic              sel_valid, timed_out;
  logic [BLK_W-1:0]  sel_res;

  // The pointer advances only when a response is delivered, so an aborted
  // (reset) operation does not count as a turn.
  rr_arb2 u_arb (
    .clk       (clk),
    .nreset    (nreset),
    .req       (bus.req_valid),
    .update    (resp_done),
    .upd_idx   (grant_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    abort     = 1'b0;
    resp_done = 1'b0;
    // Only the core matching the latched op is listened to.
    sel_valid = dec_q ? bus.eng_dec_valid : bus.eng_enc_valid;
    sel_res   = dec_q ? bus.eng_dec_res   : bus.eng_enc_res;
    timed_out = (timer_q == TMR_MAX);

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the final cycle still beats the timeout.
        if (sel_valid) begin
          state_d = ST_RESP;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Nothing is handed out or accepted while reset is asserted.
    if (!nreset) begin
      accept    = 1'b0;
      abort     = 1'b0;
      resp_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      key_q      <= '0;
      data_q     <= '0;
      dec_q      <= 1'b0;
      grant_q    <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      // Operands are sampled only in the accept cycle and then held, which
      // keeps eng_key/eng_data stable from ISSUE through WAIT.
      if (accept) begin
        key_q   <= gnt_idx ? bus.req_key[2*BLK_W-1:BLK_W]  : bus.req_key[BLK_W-1:0];
        data_q  <= gnt_idx ? bus.req_data[2*BLK_W-1:BLK_W] : bus.req_data[BLK_W-1:0];
        dec_q   <= bus.req_dec[gnt_idx];
        grant_q <= gnt_idx;
      end

      if (state_q == ST_ISSUE) begin
        timer_q <= '0;
      end else if (state_q == ST_WAIT) begin
        timer_q <= timer_q + TMR_W'(1);
      end

      if (state_q == ST_WAIT) begin
        if (sel_valid) begin
          rsp_data_q <= sel_res;
          rsp_err_q  <= 1'b0;
        end else if (timed_out) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready     = accept ? idx_to_onehot(gnt_idx) : '0;
  assign bus.eng_enc_start = nreset && (state_q == ST_ISSUE) && !dec_q;
  assign bus.eng_dec_start = nreset && (state_q == ST_ISSUE) &&  dec_q;
  assign bus.eng_key       = key_q;
  assign bus.eng_data      = data_q;
  assign bus.rsp_valid     = resp_done ? idx_to_onehot(grant_q) : '0;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;

  assign busy       = (state_q != ST_IDLE);
  assign eng_nreset = nreset & ~abort;

endmodule

// File: tb/tb_aes_arbiter.sv
// tb/tb_aes_arbiter.sv - self-checking bench for aes_arbiter
module tb_aes_arbiter;
  import aes_arb_pkg::*;

  localparam int          TMO     = 63;
  localparam logic [127:0] VEC_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic nreset;
  logic busy;
  logic eng_nreset;

  aes_arbiter_if bus ();

  aes_arbiter #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .bus        (bus),
    .busy       (busy),
    .eng_nreset (eng_nreset)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side view: what each requester currently asks for.
  logic [127:0] key_t  [2];
  logic [127:0] data_t [2];
  logic         dec_t  [2];
  logic         pending[2];
  int           last_grant_m;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in for the AES cores: known vector for the directed case,
  // otherwise an easily recomputed mix so enc and dec results differ.
  function automatic logic [127:0] eng_model(input logic [127:0] k, input logic [127:0] d, input logic dec);
    if (!dec && k == VEC_KEY && d == VEC_PT) return VEC_CT;
    return dec ? (k ^ {d[63:0], d[127:64]}) : (k + d);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round-robin rule: lone requester wins; tie goes to the one not served last.
  function automatic int pick(input int lg);
    if (pending[0] && pending[1]) return 1 - lg;
    return pending[1] ? 1 : 0;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < 2; i++) begin
      bus.req_valid[i]            = pending[i];
      bus.req_dec[i]              = dec_t[i];
      bus.req_key[i*128 +: 128]   = key_t[i];
      bus.req_data[i*128 +: 128]  = data_t[i];
    end
  endtask

  task automatic arm(input int idx, input logic [127:0] k, input logic [127:0] d, input logic dec);
    key_t[idx]   = k;
    data_t[idx]  = d;
    dec_t[idx]   = dec;
    pending[idx] = 1'b1;
  endtask

  task automatic arm_rand(input int idx, input logic dec);
    arm(idx, rand128(), rand128(), dec);
  endtask

  // One full operation starting in an IDLE cycle. lat = WAIT cycle index at
  // which the selected core answers, or -1 for a core that never answers.
  task automatic run_op(input string name, input int lat, input bit inject, output int w_obs);
    int           w, waited, starts;
    bit           done;
    logic [127:0] k, d, exp_data;
    logic         dc, exp_err;

    w  = pick(last_grant_m);
    k  = key_t[w];
    d  = data_t[w];
    dc = dec_t[w];
    exp_data = (lat < 0) ? 128'h0 : eng_model(k, d, dc);
    exp_err  = (lat < 0);

    drive_reqs();
    #1;
    waited = 0;
    while (bus.req_ready == 2'b00 && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    w_obs = bus.req_ready[1] ? 1 : 0;
    chk({name, ":accept_wait"}, waited, 0);
    chk({name, ":req_ready"}, bus.req_ready, (w == 1) ? 2'b10 : 2'b01);
    if (waited >= 8) return;

    // ISSUE
    @(negedge clk); #1;
    pending[w] = 1'b0;
    drive_reqs();
    #1;
    chk({name, ":enc_start"}, bus.eng_enc_start, !dc);
    chk({name, ":dec_start"}, bus.eng_dec_start, dc);
    chk({name, ":eng_key"}, bus.eng_key, k);
    chk({name, ":eng_data"}, bus.eng_data, d);
    chk({name, ":ready_issue"}, bus.req_ready, 2'b00);

    // WAIT
    @(negedge clk); #1;
    starts = 0;
    done   = 1'b0;
    for (int i = 0; i <= TMO && !done; i++) begin
      bus.eng_enc_valid = 1'b0;
      bus.eng_dec_valid = 1'b0;
      bus.eng_enc_res   = eng_model(k, d, 1'b0);
      bus.eng_dec_res   = eng_model(k, d, 1'b1);
      if (inject && i == 0) begin
        if (dc) bus.eng_enc_valid = 1'b1;
        else    bus.eng_dec_valid = 1'b1;
      end
      if (i == lat) begin
        if (dc) bus.eng_dec_valid = 1'b1;
        else    bus.eng_enc_valid = 1'b1;
      end
      #1;
      starts += int'(bus.eng_enc_start) + int'(bus.eng_dec_start);
      chk({name, ":eng_nreset"}, eng_nreset, !(lat < 0 && i == TMO));
      chk({name, ":no_rsp_wait"}, bus.rsp_valid, 2'b00);
      done = (i == lat) || (lat < 0 && i == TMO);
      @(negedge clk); #1;
    end

    // RESP
    bus.eng_enc_valid = 1'b0;
    bus.eng_dec_valid = 1'b0;
    #1;
    chk({name, ":extra_starts"}, starts, 0);
    chk({name, ":rsp_valid"}, bus.rsp_valid, (w == 1) ? 2'b10 : 2'b01);
    chk({name, ":rsp_data"}, bus.rsp_data, exp_data);
    chk({name, ":rsp_err"}, bus.rsp_err, exp_err);
    chk({name, ":ready_resp"}, bus.req_ready, 2'b00);
    chk({name, ":busy_resp"}, busy, 1'b1);
    last_grant_m = w;

    // back in IDLE: pulse over, result held
    @(negedge clk); #1;
    chk({name, ":rsp_pulse"}, bus.rsp_valid, 2'b00);
    chk({name, ":rsp_hold"}, bus.rsp_data, exp_data);
  endtask

  initial begin : main
    int w, lat;
    bit inj;

    for (int i = 0; i < 2; i++) begin
      pending[i] = 1'b0;
      key_t[i]   = '0;
      data_t[i]  = '0;
      dec_t[i]   = 1'b0;
    end
    bus.eng_enc_valid = 1'b0;
    bus.eng_dec_valid = 1'b0;
    bus.eng_enc_res   = '0;
    bus.eng_dec_res   = '0;
    last_grant_m      = 1;

    // Reset with a request present: nothing may be accepted.
    nreset = 1'b0;
    arm_rand(0, 1'b0);
    drive_reqs();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst:req_ready", bus.req_ready, 2'b00);
    chk("rst:rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst:busy", busy, 1'b0);
    chk("rst:eng_nreset", eng_nreset, 1'b0);
    chk("rst:enc_start", bus.eng_enc_start, 1'b0);
    chk("rst:dec_start", bus.eng_dec_start, 1'b0);
    chk("rst:rsp_data", bus.rsp_data, 128'h0);
    chk("rst:rsp_err", bus.rsp_err, 1'b0);
    chk("rst:eng_key", bus.eng_key, 128'h0);
    pending[0] = 1'b0;
    drive_reqs();
    nreset = 1'b1;

    // Tie held across four operations: order must be 0,1,0,1.
    arm_rand(0, 1'($urandom_range(0, 1)));
    arm_rand(1, 1'($urandom_range(0, 1)));
    for (int kk = 0; kk < 4; kk++) begin
      run_op("tie", $urandom_range(0, 6), 1'b0, w);
      chk("tie:order", w, kk % 2);
      if (kk < 3) arm_rand(w, 1'($urandom_range(0, 1)));
    end
    run_op("tie_drain", 2, 1'b0, w);

    // Known encrypt vector on the UART path.
    arm(0, VEC_KEY, VEC_PT, 1'b0);
    run_op("enc_vec", 3, 1'b0, w);
    chk("enc_vec:ct", bus.rsp_data, VEC_CT);

    // Decrypt routing with a stray encrypt-core valid.
    arm_rand(1, 1'b1);
    run_op("dec_route", 5, 1'b1, w);

    // Valid on the very last WAIT cycle beats the timeout.
    arm_rand(0, 1'b0);
    run_op("edge_valid", TMO, 1'b0, w);

    // Core never answers.
    arm_rand(0, 1'b0);
    run_op("timeout", -1, 1'b0, w);

    // Reset in the middle of WAIT.
    arm_rand(0, 1'b0);
    drive_reqs();
    #1;
    chk("mr:accept", bus.req_ready, 2'b01);
    @(negedge clk); #1;
    pending[0] = 1'b0;
    drive_reqs();
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("mr:busy_wait", busy, 1'b1);
    nreset = 1'b0;
    #1;
    chk("mr:eng_nreset_low", eng_nreset, 1'b0);
    @(negedge clk); #1;
    nreset = 1'b1;
    #1;
    chk("mr:busy", busy, 1'b0);
    chk("mr:rsp_valid", bus.rsp_valid, 2'b00);
    chk("mr:eng_nreset", eng_nreset, 1'b1);
    chk("mr:rsp_err", bus.rsp_err, 1'b0);
    chk("mr:rsp_data", bus.rsp_data, 128'h0);
    last_grant_m = 1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("mr:quiet_rsp", bus.rsp_valid, 2'b00);
      chk("mr:quiet_busy", busy, 1'b0);
    end
    arm_rand(1, 1'b1);
    arm_rand(0, 1'b0);
    run_op("post_rst", 4, 1'b0, w);
    chk("post_rst:winner", w, 0);

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      for (int r = 0; r < 2; r++)
        if (!pending[r] && $urandom_range(0, 1) == 1) arm_rand(r, 1'($urandom_range(0, 1)));
      if (!pending[0] && !pending[1]) arm_rand($urandom_range(0, 1), 1'($urandom_range(0, 1)));
      lat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 12);
      inj = 1'($urandom_range(0, 1));
      run_op("rand", lat, inj, w);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_arbiter.md
AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 63: maximum WAIT cycles before the operation is aborted.
REQ-002 clk  in  1  single clock, all logic on its rising edge.
REQ-003 nreset  in  1  synchronous, active-low reset.
REQ-004 req_valid  in  2  per-requester request; bit0 = UART command path, bit1 = CatCore decrypt path.
REQ-005 req_ready  out  2  one-cycle accept pulse to the granted requester.
REQ-006 req_dec  in  2  per-requester op select: 1 = decrypt, 0 = encrypt.
REQ-007 req_key  in  256  per-requester 128-bit key; requester N uses [128N+127:128N].
REQ-008 req_data  in  256  per-requester 128-bit block, same slicing as req_key.
REQ-009 rsp_valid  out  2  one-cycle response strobe to the owning requester.
REQ-010 rsp_data  out  128  result, meaningful only while a rsp_valid bit is high.
REQ-011 rsp_err  out  1  timeout flag, qualified by rsp_valid.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 eng_nreset  out  1  engine reset: nreset AND NOT abort pulse.
REQ-014 eng_key, eng_data  out  128 each  operands held stable from ISSUE through WAIT.
REQ-015 eng_enc_start, eng_dec_start  out  1 each  one-cycle start strobes to the encrypt and decrypt cores.
REQ-016 eng_enc_valid, eng_dec_valid  in  1 each  core result strobes.
REQ-017 eng_enc_res, eng_dec_res  in  128 each  core results.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP. The FSM holds at most one operation in flight.
REQ-019 IDLE with any req_valid set: grant one requester, pulse its req_ready, latch its key/data/dec into the operand registers, then go to ISSUE on the next cycle.
REQ-020 Arbitration: a single requesting bit wins outright; when both are set, the winner is the requester other than last_grant; last_grant resets to 1, so requester 0 wins the first tie.
REQ-021 A requester holds req_valid until it sees req_ready; operands are sampled only in the accept cycle.
REQ-022 ISSUE: assert exactly one start strobe (eng_dec_start if latched dec = 1, else eng_enc_start) for one cycle, clear the timer, then go to WAIT.
REQ-023 WAIT: the timer increments each cycle.
 - The selected core's valid captures its result into rsp_data and moves to RESP.
 - The other core's valid is ignored.
REQ-024 Timeout: if the timer equals TIMEOUT with no valid, set rsp_err = 1, set rsp_data = 0, drive eng_nreset low for one cycle, and go to RESP.
REQ-025 Valid and timeout in the same cycle: valid wins and rsp_err = 0.
REQ-026 RESP: pulse rsp_valid[grant] for one cycle, set last_grant = grant, then go to IDLE; req_ready is never asserted in RESP.
REQ-027 Latency from accept (cycle T) to response: ISSUE at T+1; the result is captured in the cycle its valid arrives (earliest T+2, or T+2+TIMEOUT on timeout); rsp_valid follows on the next cycle.
REQ-028 Back-to-back operation: a request pending during RESP is granted in the following IDLE cycle, which bounds throughput at one operation per (engine latency + 4) cycles.
REQ-029 rsp_data and rsp_err hold their value until the next capture.

Reset
REQ-030 nreset low at a clock edge has the following effects:
 - state returns to IDLE and last_grant = 1;
 - timer and all operand registers are cleared;
 - rsp_data = 0, rsp_err = 0;
 - all strobes and ready/valid outputs are 0, and busy = 0;
 - eng_nreset = 0.
REQ-031 Reset during ISSUE or WAIT aborts the in-flight operation with no rsp_valid, and the engine is reset with it.

Structure
REQ-032 Shared package aes_arb_pkg holds:
 - the state enum;
 - requester index constants (REQ_UART = 0, REQ_CATCORE = 1);
 - the default TIMEOUT value.
REQ-033 The grant logic is a sub-module rr_arb2: a 2-way round-robin arbiter with the pointer kept inside it.

Verification
REQ-034 Single encrypt: req_valid = 01, dec = 0, key = 000102..0F, data = 00112233..FF → eng_enc_start pulses once; rsp_valid = 01 with rsp_data = 69C4E0D86A7B0430D8CDB78070B4C55A and rsp_err = 0.
REQ-035 Tie: req_valid = 11 held → grant order 0, 1, 0, 1 across four operations, with exactly one req_ready pulse per accept.
REQ-036 Decrypt routing: requester 1 with dec = 1 → only eng_dec_start pulses; an injected eng_enc_valid during WAIT is ignored; the response is delivered on rsp_valid[1].
REQ-037 Timeout: the engine never raises valid, TIMEOUT = 63 → 64 WAIT cycles, eng_nreset low for one cycle, then rsp_err = 1 and rsp_data = 0.
REQ-038 Mid-WAIT reset: nreset low for one cycle while in WAIT → no rsp_valid and busy = 0; a subsequent request completes normally.
